// File: rtl/fu_complete_arbiter.sv
// Completion arbiter: grants up to CDB_WIDTH FU results per cycle with rotating priority.
// Latency: request in cycle t, registered CDB broadcast visible in cycle t+2.
// Backpressure: losers and all requesters under cdb_stall see fu_complete_stall in t+1.
package fu_complete_pkg;
  typedef struct packed {
    logic        valid;
    logic        halt;
    logic [5:0]  dest_pr;
    logic [31:0] dest_value;
    logic [4:0]  rob_entry;
  } fu_complete_packet_t;

  localparam int PKT_W = $bits(fu_complete_packet_t);
endpackage

module fu_complete_arbiter
  import fu_complete_pkg::*;
#(
  parameter  int NUM_FU    = 4,
  parameter  int CDB_WIDTH = 2,
  localparam int PTR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_FU-1:0]           fu_want_to_complete,
  input  logic [NUM_FU*PKT_W-1:0]     fu_packets,
  input  logic                        cdb_stall,
  output logic [NUM_FU-1:0]           fu_complete_stall,
  output logic [CDB_WIDTH*PKT_W-1:0]  cdb_packets,
  output logic [PTR_W-1:0]            rr_ptr
);

  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_FU) s = s - NUM_FU;
    return PTR_W'(s);
  endfunction

  fu_complete_packet_t [NUM_FU-1:0]    pkt;
  fu_complete_packet_t [CDB_WIDTH-1:0] cdb_next;
  fu_complete_packet_t [CDB_WIDTH-1:0] cdb_q;

  logic [NUM_FU-1:0] grant_next;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] req;
  logic [PTR_W-1:0]  arb_ptr;
  logic [PTR_W-1:0]  last_idx;
  logic [PTR_W-1:0]  aidx;
  logic [PTR_W-1:0]  cidx;
  int                n_grant;
  int                slot;

  assign pkt         = fu_packets;
  assign cdb_packets = cdb_q;

  // Stall is purely register-derived: no combinational path from FU inputs.
  assign fu_complete_stall = req & ~grant;

  always_comb begin
    grant_next = '0;
    last_idx   = rr_ptr;
    aidx       = '0;
    n_grant    = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      aidx = wrap(rr_ptr, k);
      if (fu_want_to_complete[aidx] && n_grant < CDB_WIDTH) begin
        grant_next[aidx] = 1'b1;
        last_idx         = aidx;
        n_grant          = n_grant + 1;
      end
    end
    if (cdb_stall) grant_next = '0;
  end

  // Compact granted packets into slots using the priority order that produced the grant;
  // a granted FU with an invalid packet still consumes its slot so later slots keep their place.
  always_comb begin
    cdb_next = '0;
    cidx     = '0;
    slot     = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      cidx = wrap(arb_ptr, k);
      if (grant[cidx]) begin
        for (int j = 0; j < CDB_WIDTH; j++) begin
          if (j == slot && pkt[cidx].valid) cdb_next[j] = pkt[cidx];
        end
        slot = slot + 1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant   <= '0;
      req     <= '0;
      rr_ptr  <= '0;
      arb_ptr <= '0;
      cdb_q   <= '0;
    end else begin
      grant   <= grant_next;
      req     <= fu_want_to_complete;
      arb_ptr <= rr_ptr;
      cdb_q   <= cdb_next;
      if (|grant_next) rr_ptr <= wrap(last_idx, 1);
    end
  end

endmodule
